// File: rtl/anton_neopixel_pkg.sv
// Shared constants for the multi-channel NeoPixel register block.
// Holds the per-channel and global register indexes, the address-space
// decode and the bit positions inside the channel control register.
package anton_neopixel_pkg;

  localparam int BUFFER_END_DEFAULT = 511;

  // Per-channel register indexes (busAddr[3:0])
  localparam logic [3:0] REG_MAX_LO    = 4'd0;
  localparam logic [3:0] REG_MAX_HI    = 4'd1;
  localparam logic [3:0] REG_CTRL      = 4'd2;
  localparam logic [3:0] REG_STATUS    = 4'd3;
  localparam logic [3:0] REG_WIDTH_LO  = 4'd5;
  localparam logic [3:0] REG_WIDTH_HI  = 4'd6;
  localparam logic [3:0] REG_HEIGHT_LO = 4'd7;
  localparam logic [3:0] REG_HEIGHT_HI = 4'd8;

  // Global register indexes
  localparam logic [3:0] GREG_FRAME_STATUS = 4'd0;
  localparam logic [3:0] GREG_INIT_STATUS  = 4'd1;
  localparam logic [3:0] GREG_FRAME_EN     = 4'd2;
  localparam logic [3:0] GREG_INIT_EN      = 4'd3;
  localparam logic [3:0] GREG_CHANNELS     = 4'd4;

  // Control register bit positions
  localparam int CTRL_INIT  = 0;
  localparam int CTRL_LIMIT = 1;
  localparam int CTRL_RUN   = 2;
  localparam int CTRL_LOOP  = 3;
  localparam int CTRL_32BIT = 4;

  localparam logic [1:0] SPACE_BUFFER = 2'b00;

  typedef enum logic [1:0] {
    SP_BUFFER,
    SP_CHANNEL,
    SP_GLOBAL
  } space_e;

  function automatic space_e decode_space(input logic [17:0] addr);
    if (addr[17:16] == SPACE_BUFFER) return SP_BUFFER;
    if (addr[8]) return SP_GLOBAL;
    return SP_CHANNEL;
  endfunction

endpackage

// File: rtl/anton_neopixel_channel_regs.sv
// One strip channel's registers: control bits, geometry, the double-buffered
// max index and init sequencing.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_wr, i_idx, i_wdata    register write for this channel (idx also selects read data)
//   i_state                 streamer busy
//   i_sync_start            start pulse
//   i_stream_sync_of        end-of-frame pulse
//   i_init_slow_done        init-complete pulse
//   o_reg_max               active (committed) max index
//   o_ctrl                  {32bit, loop, run, limit, init}
//   o_init_slow             init request
//   o_rd_data               read data for i_idx
module anton_neopixel_channel_regs
  import anton_neopixel_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr,
  input  logic [3:0]  i_idx,
  input  logic [7:0]  i_wdata,
  input  logic        i_state,
  input  logic        i_sync_start,
  input  logic        i_stream_sync_of,
  input  logic        i_init_slow_done,
  output logic [12:0] o_reg_max,
  output logic [4:0]  o_ctrl,
  output logic        o_init_slow,
  output logic [7:0]  o_rd_data
);

  logic [12:0] r_pend_max;
  logic [12:0] r_reg_max;
  logic        r_commit_pending;
  logic [4:0]  r_ctrl;
  logic        r_init_slow;
  logic [13:0] r_width;
  logic [13:0] r_height;
  logic        w_ctrl_wr;

  assign w_ctrl_wr = i_wr && (i_idx == REG_CTRL);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_max       <= '0;
      r_reg_max        <= '0;
      r_commit_pending <= 1'b0;
      r_ctrl           <= '0;
      r_init_slow      <= 1'b0;
      r_width          <= '0;
      r_height         <= '0;
    end else begin
      // Commit only while the streamer is idle or exactly at end of frame.
      if (r_commit_pending && (!i_state || i_stream_sync_of)) begin
        r_reg_max        <= r_pend_max;
        r_commit_pending <= 1'b0;
      end
      // A same-cycle write re-arms the commit; the commit above took the old value.
      if (i_wr && i_idx == REG_MAX_LO) begin
        r_pend_max[7:0]  <= i_wdata;
        r_commit_pending <= 1'b1;
      end
      if (i_wr && i_idx == REG_MAX_HI) begin
        r_pend_max[12:8] <= i_wdata[4:0];
        r_commit_pending <= 1'b1;
      end

      if (w_ctrl_wr) begin
        r_ctrl <= i_wdata[4:0];
      end else begin
        if (r_ctrl[CTRL_INIT]) begin
          r_ctrl[CTRL_LIMIT] <= 1'b0;
          r_ctrl[CTRL_RUN]   <= 1'b0;
          r_ctrl[CTRL_LOOP]  <= 1'b0;
          r_ctrl[CTRL_32BIT] <= 1'b0;
        end else if (i_sync_start) begin
          r_ctrl[CTRL_RUN] <= 1'b1;
        end else if (i_stream_sync_of) begin
          r_ctrl[CTRL_RUN] <= r_ctrl[CTRL_LOOP];
        end
        if (i_init_slow_done) r_ctrl[CTRL_INIT] <= 1'b0;
      end

      if (i_init_slow_done && !w_ctrl_wr) r_init_slow <= 1'b0;
      else if (r_ctrl[CTRL_INIT])         r_init_slow <= 1'b1;

      if (i_wr && i_idx == REG_WIDTH_LO)  r_width[7:0]   <= i_wdata;
      if (i_wr && i_idx == REG_WIDTH_HI)  r_width[13:8]  <= i_wdata[5:0];
      if (i_wr && i_idx == REG_HEIGHT_LO) r_height[7:0]  <= i_wdata;
      if (i_wr && i_idx == REG_HEIGHT_HI) r_height[13:8] <= i_wdata[5:0];
    end
  end

  always_comb begin
    o_rd_data = 8'h00;
    case (i_idx)
      REG_MAX_LO:    o_rd_data = r_pend_max[7:0];
      REG_MAX_HI:    o_rd_data = {3'b000, r_pend_max[12:8]};
      REG_CTRL:      o_rd_data = {3'b000, r_ctrl};
      REG_STATUS:    o_rd_data = {6'b000000, r_commit_pending, i_state};
      REG_WIDTH_LO:  o_rd_data = r_width[7:0];
      REG_WIDTH_HI:  o_rd_data = {2'b00, r_width[13:8]};
      REG_HEIGHT_LO: o_rd_data = r_height[7:0];
      REG_HEIGHT_HI: o_rd_data = {2'b00, r_height[13:8]};
      default:       o_rd_data = 8'h00;
    endcase
  end

  assign o_reg_max   = r_reg_max;
  assign o_ctrl      = r_ctrl;
  assign o_init_slow = r_init_slow;

endmodule

// File: rtl/anton_neopixel_registers_multi.sv
// Byte-wide bus slave for CHANNELS NeoPixel strip controllers.
// Decodes the bus into pixel-RAM write strobes, per-channel register banks
// and a global interrupt status/enable block.
// Ports:
//   busClk, busResetN                 clock, async active-low reset
//   busAddr/busDataIn/busWrite/busRead  bus request; busDataOut read data (1-cycle latency)
//   ramWr/ramWAddr/ramWData           registered pixel-RAM write (one strobe per channel)
//   state/syncStart/streamSyncOf/initSlowDone  per-channel streamer events
//   regMax                            committed max index, channel c at [13c+12:13c]
//   regCtrl*                          per-channel control bits
//   initSlow                          per-channel init request
//   irq                               level interrupt
module anton_neopixel_registers_multi
  import anton_neopixel_pkg::*;
#(
  parameter int  CHANNELS    = 4,
  parameter int  BUFFER_END  = BUFFER_END_DEFAULT,
  parameter int  BUFFER_BITS = $clog2(BUFFER_END + 1),
  localparam int CH_BITS     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                     busClk,
  input  logic                     busResetN,
  input  logic [17:0]              busAddr,
  input  logic [7:0]               busDataIn,
  input  logic                     busWrite,
  input  logic                     busRead,
  output logic [7:0]               busDataOut,
  output logic [CHANNELS-1:0]      ramWr,
  output logic [BUFFER_BITS-1:0]   ramWAddr,
  output logic [7:0]               ramWData,
  input  logic [CHANNELS-1:0]      state,
  input  logic [CHANNELS-1:0]      syncStart,
  input  logic [CHANNELS-1:0]      streamSyncOf,
  input  logic [CHANNELS-1:0]      initSlowDone,
  output logic [CHANNELS*13-1:0]   regMax,
  output logic [CHANNELS-1:0]      regCtrlInit,
  output logic [CHANNELS-1:0]      regCtrlLimit,
  output logic [CHANNELS-1:0]      regCtrlRun,
  output logic [CHANNELS-1:0]      regCtrlLoop,
  output logic [CHANNELS-1:0]      regCtrl32bit,
  output logic [CHANNELS-1:0]      initSlow,
  output logic                     irq
);

  // Channel and buffer index share the low 16 address bits.
  space_e                w_space;
  logic [2:0]            w_reg_ch;
  logic [3:0]            w_idx;
  logic                  w_reg_ch_ok;
  logic [CH_BITS-1:0]    w_buf_ch;
  logic                  w_buf_ch_ok;
  logic                  w_reg_wr;
  logic                  w_glb_wr;
  logic [CHANNELS-1:0]   w_frame_clr;
  logic [CHANNELS-1:0]   w_init_clr;
  logic [7:0]            w_rd_data;
  logic [7:0]            w_ch_rd [8];
  logic                  w_unused_addr;

  logic [CHANNELS-1:0]    r_ram_wr;
  logic [BUFFER_BITS-1:0] r_ram_waddr;
  logic [7:0]             r_ram_wdata;
  logic [CHANNELS-1:0]    r_frame_done;
  logic [CHANNELS-1:0]    r_init_done;
  logic [CHANNELS-1:0]    r_frame_en;
  logic [CHANNELS-1:0]    r_init_en;
  logic                   r_irq;
  logic [7:0]             r_bus_data_out;

  assign w_space       = decode_space(busAddr);
  assign w_reg_ch      = busAddr[6:4];
  assign w_idx         = busAddr[3:0];
  assign w_reg_ch_ok   = 32'(w_reg_ch) < CHANNELS;
  assign w_buf_ch      = busAddr[BUFFER_BITS +: CH_BITS];
  assign w_buf_ch_ok   = 32'(w_buf_ch) < CHANNELS;
  assign w_reg_wr      = busWrite && (w_space == SP_CHANNEL) && w_reg_ch_ok;
  assign w_glb_wr      = busWrite && (w_space == SP_GLOBAL);
  assign w_frame_clr   = (w_glb_wr && w_idx == GREG_FRAME_STATUS) ? busDataIn[CHANNELS-1:0] : '0;
  assign w_init_clr    = (w_glb_wr && w_idx == GREG_INIT_STATUS)  ? busDataIn[CHANNELS-1:0] : '0;
  assign w_unused_addr = ^busAddr;

  for (genvar c = 0; c < 8; c++) begin : g_ch
    if (c < CHANNELS) begin : g_on
      logic [4:0] w_ctrl;
      anton_neopixel_channel_regs u_regs (
        .i_clk            (busClk),
        .i_rst_n          (busResetN),
        .i_wr             (w_reg_wr && (w_reg_ch == 3'(c))),
        .i_idx            (w_idx),
        .i_wdata          (busDataIn),
        .i_state          (state[c]),
        .i_sync_start     (syncStart[c]),
        .i_stream_sync_of (streamSyncOf[c]),
        .i_init_slow_done (initSlowDone[c]),
        .o_reg_max        (regMax[13*c +: 13]),
        .o_ctrl           (w_ctrl),
        .o_init_slow      (initSlow[c]),
        .o_rd_data        (w_ch_rd[c])
      );
      assign regCtrlInit[c]  = w_ctrl[CTRL_INIT];
      assign regCtrlLimit[c] = w_ctrl[CTRL_LIMIT];
      assign regCtrlRun[c]   = w_ctrl[CTRL_RUN];
      assign regCtrlLoop[c]  = w_ctrl[CTRL_LOOP];
      assign regCtrl32bit[c] = w_ctrl[CTRL_32BIT];
    end else begin : g_off
      assign w_ch_rd[c] = 8'h00;
    end
  end

  always_comb begin
    w_rd_data = 8'h00;
    case (w_space)
      SP_BUFFER: w_rd_data = 8'hFF;
      SP_GLOBAL: begin
        case (w_idx)
          GREG_FRAME_STATUS: w_rd_data = 8'(r_frame_done);
          GREG_INIT_STATUS:  w_rd_data = 8'(r_init_done);
          GREG_FRAME_EN:     w_rd_data = 8'(r_frame_en);
          GREG_INIT_EN:      w_rd_data = 8'(r_init_en);
          GREG_CHANNELS:     w_rd_data = 8'(CHANNELS);
          default:           w_rd_data = 8'h00;
        endcase
      end
      default: if (w_reg_ch_ok) w_rd_data = w_ch_rd[w_reg_ch];
    endcase
  end

  always_ff @(posedge busClk or negedge busResetN) begin
    if (!busResetN) begin
      r_ram_wr       <= '0;
      r_ram_waddr    <= '0;
      r_ram_wdata    <= '0;
      r_frame_done   <= '0;
      r_init_done    <= '0;
      r_frame_en     <= '0;
      r_init_en      <= '0;
      r_irq          <= 1'b0;
      r_bus_data_out <= 8'h00;
    end else begin
      r_ram_wr <= '0;
      if (busWrite && w_space == SP_BUFFER) begin
        if (w_buf_ch_ok) r_ram_wr <= CHANNELS'(1) << w_buf_ch;
        r_ram_waddr <= busAddr[BUFFER_BITS-1:0];
        r_ram_wdata <= busDataIn;
      end
      // New events win over a same-cycle write-1-to-clear.
      r_frame_done <= (r_frame_done & ~w_frame_clr) | streamSyncOf;
      r_init_done  <= (r_init_done & ~w_init_clr) | initSlowDone;
      if (w_glb_wr && w_idx == GREG_FRAME_EN) r_frame_en <= busDataIn[CHANNELS-1:0];
      if (w_glb_wr && w_idx == GREG_INIT_EN)  r_init_en  <= busDataIn[CHANNELS-1:0];
      r_irq <= |((r_frame_done & r_frame_en) | (r_init_done & r_init_en));
      if (busRead) r_bus_data_out <= w_rd_data;
    end
  end

  assign ramWr      = r_ram_wr;
  assign ramWAddr   = r_ram_waddr;
  assign ramWData   = r_ram_wdata;
  assign irq        = r_irq;
  assign busDataOut = r_bus_data_out;

endmodule

// File: doc/anton_neopixel_registers_multi.md
Name: anton_neopixel_registers_multi

Overview:
- Multi-channel successor of the single-strip NeoPixel register file: one byte-wide bus slave serving CHANNELS independent strip controllers.
- Per channel: control and geometry registers, a double-buffered regMax that commits at frame boundaries, and init sequencing.
- Global: sticky write-1-to-clear interrupt status with enables.
- Pixel RAMs sit outside the block; it decodes bus writes into per-channel RAM write strobes.

Parameters:
- CHANNELS, 4, number of strip channels (1..8).
- BUFFER_END, `BUFFER_END_DEFAULT, last pixel-byte index per channel; BUFFER_BITS = `CLOG2(BUFFER_END+1).
- CH_BITS, `CLOG2(CHANNELS) (min 1), derived; BUFFER_BITS+CH_BITS <= 16 is a hard constraint.

Ports:
- busClk in 1: single clock.
- busResetN in 1: asynchronous active-low reset.
- busAddr in 18: byte address.
- busDataIn in 8: write data.
- busWrite in 1: one-cycle write strobe.
- busRead in 1: one-cycle read strobe.
- busDataOut out 8: read data.
- ramWr out CHANNELS: per-channel RAM write strobe.
- ramWAddr out BUFFER_BITS: shared RAM write address.
- ramWData out 8: shared RAM write data.
- state in CHANNELS: per-channel streamer busy.
- syncStart in CHANNELS: per-channel start pulse.
- streamSyncOf in CHANNELS: per-channel end-of-frame pulse.
- initSlowDone in CHANNELS: per-channel init-complete pulse.
- regMax out CHANNELS*13: active max index, channel c at [13c+12:13c].
- regCtrlInit, regCtrlLimit, regCtrlRun, regCtrlLoop, regCtrl32bit out CHANNELS each: control bits.
- initSlow out CHANNELS: init request.
- irq out 1: level interrupt.

Behaviour:
- Reset (busResetN low, async): all registers, outputs, pending/active regMax, status and enables are 0; busDataOut 0x00.
- Buffer space, busAddr[17:16]==00:
  - Channel = busAddr[BUFFER_BITS+CH_BITS-1:BUFFER_BITS].
  - A write registers ramWr[ch]=1, ramWAddr, ramWData one cycle after busWrite.
  - A channel index >= CHANNELS produces no strobe.
  - Reads return 0xFF.
- Register space, busAddr[17:16]!=00, busAddr[8]==0:
  - Channel = busAddr[6:4]; index = busAddr[3:0]; channel >= CHANNELS is ignored and reads 0x00.
  - Idx 0/1: pendMax[7:0] / pendMax[12:8]. A write sets commitPending.
  - Idx 2: {32bit, loop, run, limit, init} in bits [4:0].
  - Idx 3 (RO): {6'b0, commitPending, state[ch]}.
  - Idx 5/6: width [7:0] / [13:8].
  - Idx 7/8: height [7:0] / [13:8].
  - Other indexes read 0x00 and ignore writes.
- Global space, busAddr[8]==1, index busAddr[3:0]:
  - 0: frameDone status, W1C.
  - 1: initDone status, W1C.
  - 2: frameDone enable.
  - 3: initDone enable.
  - 4 (RO): CHANNELS.
  - Status and enable bits above CHANNELS read 0.
- Reads: latency 1. busDataOut updates the cycle after busRead and holds its value otherwise.
- regMax commit: active <= pending while commitPending, either when state[ch]==0 or in the cycle streamSyncOf[ch]=1. Commit clears commitPending. A bus write in the same cycle as a commit re-arms commitPending; the commit uses the old pending value.
- Per-channel run priority, highest first:
  - bus write to ctrl;
  - init clear;
  - syncStart (run<=1);
  - streamSyncOf (run<=loop).
- Init:
  - While regCtrlInit=1: each cycle clears limit/run/loop/32bit and sets initSlow.
  - initSlowDone clears init and initSlow, and sets initDone status.
  - If a bus write to ctrl lands in that same cycle, the write wins.
- Status bits:
  - streamSyncOf[ch] sets frameDone[ch].
  - A set in the same cycle as a W1C clear wins.
  - irq = |(frameDone&frameEn | initDone&initEn), registered, 1-cycle lag.
- Reset mid-frame: all outputs drop immediately; no pending commit survives.

Decomposition:
- Package anton_neopixel_pkg.vh: register index constants (REG_MAX_LO..REG_HEIGHT_HI, GREG_*), space-select constants, and ctrl bit positions.
- Sub-module anton_neopixel_channel_regs, instantiated CHANNELS times via generate: holds one channel's ctrl, geometry, shadow regMax and init logic.
- Top level keeps address decode, read mux, RAM strobe and IRQ logic.

Test Plan:
- Reset/defaults: CHANNELS=4; assert reset, then write buffer 0x0_0105=0xAB with BUFFER_BITS=9. Expect ramWr=4'b0000, then after one write to ch2 @ addr (2<<9)|5, ramWr=4'b0100, ramWAddr=5, ramWData=0xAB.
- Shadow commit:
  - ch1 state=1; write idx0=0x10, idx1=0x01. Expect regMax ch1=0 and idx3 reads 0x03.
  - Pulse streamSyncOf[1]. Next cycle regMax ch1=0x110 and idx3 reads 0x01.
- Run priority: ch0 loop=1, run=1; pulse streamSyncOf[0] and syncStart[0] together. Expect run stays 1. Then loop=0 and streamSyncOf alone. Expect run=0.
- Init: write ch3 ctrl=0x1F. Expect next cycle limit/run/loop/32bit=0 and initSlow[3]=1. Pulse initSlowDone[3]. Expect init=0, initSlow=0, initDone[3]=1.
- IRQ W1C race: initEn=0x08. Write global idx1=0x08 in the same cycle as a new initSlowDone[3]. Expect the bit stays 1 and irq stays 1. A later clear alone gives irq=0 one cycle after the status clears.
- Read latency/unmapped: read ch5 (>=CHANNELS) idx0 returns 0x00. Global idx4 returns 0x04 one cycle after busRead. busDataOut holds 0x04 on idle cycles.
